// File: rtl/pcie_us_pkg.sv
// pcie_us_pkg: CQ request type codes, CC status codes and descriptor field offsets
package pcie_us_pkg;
  typedef enum logic [3:0] {
    REQ_MEM_RD      = 4'b0000,
    REQ_MEM_WR      = 4'b0001,
    REQ_IO_RD       = 4'b0010,
    REQ_IO_WR       = 4'b0011,
    REQ_FETCH_ADD   = 4'b0100,
    REQ_SWAP        = 4'b0101,
    REQ_CAS         = 4'b0110,
    REQ_MEM_RD_LOCK = 4'b0111,
    REQ_CFG_RD0     = 4'b1000,
    REQ_CFG_RD1     = 4'b1001,
    REQ_CFG_WR0     = 4'b1010,
    REQ_CFG_WR1     = 4'b1011,
    REQ_MSG         = 4'b1100,
    REQ_MSG_VEND    = 4'b1101,
    REQ_MSG_ATS     = 4'b1110,
    REQ_RSVD        = 4'b1111
  } req_type_e;
  typedef enum logic [2:0] {
    CPL_SC  = 3'b000,
    CPL_UR  = 3'b001,
    CPL_CRS = 3'b010,
    CPL_CA  = 3'b100
  } cpl_status_e;
  localparam int CQ_DWC_LSB    = 64;
  localparam int CQ_TYPE_LSB   = 75;
  localparam int CQ_RID_LSB    = 80;
  localparam int CQ_TAG_LSB    = 96;
  localparam int CQ_FUNC_LSB   = 104;
  localparam int CQ_TC_LSB     = 121;
  localparam int CQ_ATTR_LSB   = 124;
  localparam int CQ_DATA_LSB   = 128;
  localparam int CC_LADDR_LSB  = 0;
  localparam int CC_BC_LSB     = 16;
  localparam int CC_DWC_LSB    = 32;
  localparam int CC_STATUS_LSB = 43;
  localparam int CC_RID_LSB    = 48;
  localparam int CC_TAG_LSB    = 64;
  localparam int CC_FUNC_LSB   = 72;
  localparam int CC_TC_LSB     = 89;
  localparam int CC_ATTR_LSB   = 92;
  localparam int CC_DATA_LSB   = 96;
  // memory writes and messages never take a completion
  function automatic logic is_posted(input logic [3:0] t);
    return t == REQ_MEM_WR || t == REQ_MSG || t == REQ_MSG_VEND || t == REQ_MSG_ATS;
  endfunction
  function automatic logic [1:0] be_offset(input logic [3:0] be);
    return be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : be[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/pcie_cq_reg_completer_if.sv
// pcie_cq_reg_completer_if: CQ sink, CC source and register port bundle
interface pcie_cq_reg_completer_if #(
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 32,
  parameter int CQ_USER_WIDTH  = 183,
  parameter int CC_USER_WIDTH  = 81,
  parameter int REG_ADDR_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]     s_axis_cq_tdata;
  logic [KEEP_WIDTH-1:0]     s_axis_cq_tkeep;
  logic                      s_axis_cq_tvalid;
  logic                      s_axis_cq_tready;
  logic                      s_axis_cq_tlast;
  logic [CQ_USER_WIDTH-1:0]  s_axis_cq_tuser;
  logic [DATA_WIDTH-1:0]     m_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]     m_axis_cc_tkeep;
  logic                      m_axis_cc_tvalid;
  logic                      m_axis_cc_tready;
  logic                      m_axis_cc_tlast;
  logic [CC_USER_WIDTH-1:0]  m_axis_cc_tuser;
  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]               reg_wr_data;
  logic [3:0]                reg_wr_strb;
  logic                      reg_wr_en;
  logic                      reg_rd_en;
  logic [31:0]               reg_rd_data;
  logic                      reg_ack;
  logic                      status_error_uncor;
  modport slave (
    input  s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tvalid, s_axis_cq_tlast, s_axis_cq_tuser,
    output s_axis_cq_tready,
    output m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tuser,
    input  m_axis_cc_tready,
    output reg_addr, reg_wr_data, reg_wr_strb, reg_wr_en, reg_rd_en,
    input  reg_rd_data, reg_ack,
    output status_error_uncor
  );
  modport master (
    output s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tvalid, s_axis_cq_tlast, s_axis_cq_tuser,
    input  s_axis_cq_tready,
    input  m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tuser,
    output m_axis_cc_tready,
    input  reg_addr, reg_wr_data, reg_wr_strb, reg_wr_en, reg_rd_en,
    output reg_rd_data, reg_ack,
    input  status_error_uncor
  );
endinterface

// File: rtl/pcie_cq_reg_completer.sv
// pcie_cq_reg_completer: single-dword BAR register completer bridging PCIe CQ requests to a register port
module pcie_cq_reg_completer
  import pcie_us_pkg::*;
#(
  parameter int AXIS_PCIE_DATA_WIDTH    = 512,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 183,
  parameter int AXIS_PCIE_CC_USER_WIDTH = 81,
  parameter int REG_ADDR_WIDTH          = 24,
  parameter int TIMEOUT                 = 256
) (
  input logic clk,
  input logic rst,
  pcie_cq_reg_completer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CPL, DROP} state_e;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e state, state_nxt;
  logic [REG_ADDR_WIDTH-1:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0] be;
  logic [15:0] rid;
  logic [7:0] tag, func;
  logic [2:0] tc, attr, status;
  logic pend, err;
  logic [CNT_W-1:0] cnt;
  logic [3:0] hdr_type;
  logic [10:0] hdr_dwc;
  logic hdr_fire, wr_ok, rd_ok, busy, timeout, done;
  logic [AXIS_PCIE_DATA_WIDTH-1:0] cc_data;
  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] cq_user;
  logic unused_bits;
  assign cq_user = bus.s_axis_cq_tuser;
  assign unused_bits = ^{bus.s_axis_cq_tdata, bus.s_axis_cq_tkeep, cq_user};
  assign hdr_type = bus.s_axis_cq_tdata[CQ_TYPE_LSB +: 4];
  assign hdr_dwc = bus.s_axis_cq_tdata[CQ_DWC_LSB +: 11];
  assign hdr_fire = state == IDLE && bus.s_axis_cq_tvalid;
  assign wr_ok = hdr_type == REQ_MEM_WR && hdr_dwc == 11'd1;
  assign rd_ok = hdr_type == REQ_MEM_RD && hdr_dwc == 11'd1;
  assign busy = state == WRITE || state == READ;
  assign timeout = busy && !bus.reg_ack && cnt == CNT_W'(TIMEOUT - 1);
  assign done = busy && (bus.reg_ack || timeout);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // pend: header beat was not the last, so the tail must be drained afterwards
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.s_axis_cq_tvalid)
                 state_nxt = wr_ok ? WRITE
                           : is_posted(hdr_type) ? (bus.s_axis_cq_tlast ? IDLE : DROP)
                           : rd_ok ? READ : CPL;
      WRITE:   if (done) state_nxt = pend ? DROP : IDLE;
      READ:    if (done) state_nxt = CPL;
      CPL:     if (bus.m_axis_cc_tready) state_nxt = pend ? DROP : IDLE;
      DROP:    if (bus.s_axis_cq_tvalid && bus.s_axis_cq_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      wr_data <= '0;
      rd_data <= '0;
      be <= '0;
      rid <= '0;
      tag <= '0;
      func <= '0;
      tc <= '0;
      attr <= '0;
      status <= CPL_SC;
      pend <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      err <= (hdr_fire && !is_posted(hdr_type) && !rd_ok) || timeout;
      if (hdr_fire) begin
        addr <= {bus.s_axis_cq_tdata[REG_ADDR_WIDTH-1:2], 2'b00};
        wr_data <= bus.s_axis_cq_tdata[CQ_DATA_LSB +: 32];
        be <= cq_user[3:0];
        rid <= bus.s_axis_cq_tdata[CQ_RID_LSB +: 16];
        tag <= bus.s_axis_cq_tdata[CQ_TAG_LSB +: 8];
        func <= bus.s_axis_cq_tdata[CQ_FUNC_LSB +: 8];
        tc <= bus.s_axis_cq_tdata[CQ_TC_LSB +: 3];
        attr <= bus.s_axis_cq_tdata[CQ_ATTR_LSB +: 3];
        pend <= !bus.s_axis_cq_tlast;
        status <= CPL_UR;
        rd_data <= '0;
        cnt <= '0;
      end
      if (busy) cnt <= cnt + 1'b1;
      if (state == READ && done) begin
        rd_data <= bus.reg_ack ? bus.reg_rd_data : 32'hFFFF_FFFF;
        status <= CPL_SC;
      end
    end
  always_comb begin
    cc_data = '0;
    cc_data[CC_LADDR_LSB +: 7] = {addr[6:2], be_offset(be)};
    cc_data[CC_BC_LSB +: 13] = 13'd4;
    cc_data[CC_DWC_LSB +: 11] = status == CPL_SC ? 11'd1 : 11'd0;
    cc_data[CC_STATUS_LSB +: 3] = status;
    cc_data[CC_RID_LSB +: 16] = rid;
    cc_data[CC_TAG_LSB +: 8] = tag;
    cc_data[CC_FUNC_LSB +: 8] = func;
    cc_data[CC_TC_LSB +: 3] = tc;
    cc_data[CC_ATTR_LSB +: 3] = attr;
    cc_data[CC_DATA_LSB +: 32] = rd_data;
  end
  assign bus.s_axis_cq_tready = state == IDLE || state == DROP;
  assign bus.m_axis_cc_tdata = cc_data;
  assign bus.m_axis_cc_tkeep = status == CPL_SC ? AXIS_PCIE_KEEP_WIDTH'(4'hF) : AXIS_PCIE_KEEP_WIDTH'(4'h7);
  assign bus.m_axis_cc_tvalid = state == CPL;
  assign bus.m_axis_cc_tlast = 1'b1;
  assign bus.m_axis_cc_tuser = {AXIS_PCIE_CC_USER_WIDTH{1'b0}};
  assign bus.reg_addr = addr;
  assign bus.reg_wr_data = wr_data;
  assign bus.reg_wr_strb = be;
  assign bus.reg_wr_en = state == WRITE;
  assign bus.reg_rd_en = state == READ;
  assign bus.status_error_uncor = err;
endmodule

// File: tb/tb_pcie_cq_reg_completer.sv
// tb_pcie_cq_reg_completer: directed checks of write, read, backpressure, UR, timeout and reset abort
module tb_pcie_cq_reg_completer;
  import pcie_us_pkg::*;
  localparam logic [15:0] RID = 16'hABCD;
  localparam logic [7:0] FN = 8'h05;
  localparam logic [2:0] TC = 3'd2;
  localparam logic [2:0] AT = 3'd1;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  pcie_cq_reg_completer_if bus_if ();
  pcie_cq_reg_completer dut (.clk(clk), .rst(rst), .bus(bus_if));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [511:0] hdr(input logic [3:0] t, input logic [10:0] dwc, input logic [23:0] a,
                                       input logic [7:0] tg, input logic [31:0] d);
    logic [511:0] h;
    h = '0;
    h[23:0] = a;
    h[74:64] = dwc;
    h[78:75] = t;
    h[95:80] = RID;
    h[103:96] = tg;
    h[111:104] = FN;
    h[123:121] = TC;
    h[126:124] = AT;
    h[159:128] = d;
    return h;
  endfunction
  function automatic logic [511:0] cpl(input logic [2:0] st, input logic [10:0] dw, input logic [6:0] la,
                                       input logic [7:0] tg, input logic [31:0] d);
    logic [511:0] c;
    c = '0;
    c[6:0] = la;
    c[28:16] = 13'd4;
    c[42:32] = dw;
    c[45:43] = st;
    c[63:48] = RID;
    c[71:64] = tg;
    c[79:72] = FN;
    c[91:89] = TC;
    c[94:92] = AT;
    c[127:96] = d;
    return c;
  endfunction
  task automatic send(input logic [511:0] d, input logic [3:0] be, input logic last);
    bus_if.s_axis_cq_tdata = d;
    bus_if.s_axis_cq_tuser = 183'(be);
    bus_if.s_axis_cq_tlast = last;
    bus_if.s_axis_cq_tvalid = 1'b1;
    step();
    bus_if.s_axis_cq_tvalid = 1'b0;
    bus_if.s_axis_cq_tlast = 1'b0;
  endtask
  initial begin
    int n, m;
    logic flag, seen;
    logic [511:0] p0;
    rst = 1'b1;
    bus_if.s_axis_cq_tdata = '0;
    bus_if.s_axis_cq_tkeep = '1;
    bus_if.s_axis_cq_tvalid = 1'b0;
    bus_if.s_axis_cq_tlast = 1'b0;
    bus_if.s_axis_cq_tuser = '0;
    bus_if.m_axis_cc_tready = 1'b1;
    bus_if.reg_rd_data = '0;
    bus_if.reg_ack = 1'b0;
    repeat (3) step();
    check("rst_cc_tvalid", bus_if.m_axis_cc_tvalid, 0);
    check("rst_wr_en", bus_if.reg_wr_en, 0);
    check("rst_rd_en", bus_if.reg_rd_en, 0);
    check("rst_err", bus_if.status_error_uncor, 0);
    check("rst_addr", bus_if.reg_addr, 0);
    rst = 1'b0;
    step();
    check("rst_cq_tready", bus_if.s_axis_cq_tready, 1);
    // write, ack on the third enable cycle
    send(hdr(REQ_MEM_WR, 11'd1, 24'h000100, 8'h01, 32'hDEADBEEF), 4'hF, 1'b1);
    check("wr_en_latency", bus_if.reg_wr_en, 1);
    check("wr_addr", bus_if.reg_addr, 24'h000100);
    check("wr_data", bus_if.reg_wr_data, 32'hDEADBEEF);
    check("wr_strb", bus_if.reg_wr_strb, 4'hF);
    check("wr_cq_tready", bus_if.s_axis_cq_tready, 0);
    n = 0;
    flag = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.reg_wr_en) begin
        n++;
        flag &= bus_if.reg_addr == 24'h000100 && bus_if.reg_wr_data == 32'hDEADBEEF && bus_if.reg_wr_strb == 4'hF;
      end
      seen |= bus_if.m_axis_cc_tvalid | bus_if.reg_rd_en;
      bus_if.reg_ack = i == 2;
      step();
    end
    bus_if.reg_ack = 1'b0;
    check("wr_en_cycles", n, 3);
    check("wr_payload_stable", flag, 1);
    check("wr_no_cc", seen, 0);
    check("wr_back_idle", bus_if.s_axis_cq_tready, 1);
    // multi-dword write and a message are dropped silently
    send(hdr(REQ_MEM_WR, 11'd2, 24'h000180, 8'h02, 32'h11111111), 4'hF, 1'b0);
    check("drop_wr_en", bus_if.reg_wr_en, 0);
    check("drop_tready", bus_if.s_axis_cq_tready, 1);
    send(512'h22222222, 4'h0, 1'b1);
    check("drop_tail_idle", bus_if.s_axis_cq_tready, 1);
    send(hdr(REQ_MSG, 11'd0, 24'h0, 8'h03, 32'h0), 4'h0, 1'b1);
    check("msg_no_access", {bus_if.reg_wr_en, bus_if.reg_rd_en, bus_if.m_axis_cc_tvalid, bus_if.status_error_uncor}, 0);
    // read with one-cycle ack
    send(hdr(REQ_MEM_RD, 11'd1, 24'h000204, 8'h2A, 32'h0), 4'hF, 1'b1);
    check("rd_en_latency", bus_if.reg_rd_en, 1);
    check("rd_addr", bus_if.reg_addr, 24'h000204);
    check("rd_cq_tready", bus_if.s_axis_cq_tready, 0);
    bus_if.reg_ack = 1'b1;
    bus_if.reg_rd_data = 32'h12345678;
    step();
    bus_if.reg_ack = 1'b0;
    check("rd_cc_latency", bus_if.m_axis_cc_tvalid, 1);
    check("rd_en_dropped", bus_if.reg_rd_en, 0);
    check("rd_cc_data", bus_if.m_axis_cc_tdata, cpl(CPL_SC, 11'd1, 7'h04, 8'h2A, 32'h12345678));
    check("rd_cc_tkeep", bus_if.m_axis_cc_tkeep, 16'h000F);
    check("rd_cc_tlast", bus_if.m_axis_cc_tlast, 1);
    check("rd_cc_tuser", bus_if.m_axis_cc_tuser, 0);
    step();
    check("rd_cc_done", bus_if.m_axis_cc_tvalid, 0);
    check("rd_idle", bus_if.s_axis_cq_tready, 1);
    // completion held under backpressure, first_be 0100 gives offset 2
    bus_if.m_axis_cc_tready = 1'b0;
    send(hdr(REQ_MEM_RD, 11'd1, 24'h000010, 8'h11, 32'h0), 4'b0100, 1'b1);
    bus_if.reg_ack = 1'b1;
    bus_if.reg_rd_data = 32'hCAFEF00D;
    step();
    bus_if.reg_ack = 1'b0;
    p0 = bus_if.m_axis_cc_tdata;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flag &= bus_if.m_axis_cc_tvalid && bus_if.m_axis_cc_tdata == p0 && !bus_if.s_axis_cq_tready;
      step();
    end
    check("bp_hold", flag, 1);
    check("bp_cc_data", p0, cpl(CPL_SC, 11'd1, 7'h12, 8'h11, 32'hCAFEF00D));
    bus_if.m_axis_cc_tready = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_if.m_axis_cc_tvalid) n++;
      step();
    end
    check("bp_single_beat", n, 1);
    // unsupported: read of four dwords
    send(hdr(REQ_MEM_RD, 11'd4, 24'h00030C, 8'h33, 32'h0), 4'hF, 1'b1);
    check("ur_cc_valid", bus_if.m_axis_cc_tvalid, 1);
    check("ur_err", bus_if.status_error_uncor, 1);
    check("ur_no_reg", {bus_if.reg_wr_en, bus_if.reg_rd_en}, 0);
    check("ur_cc_data", bus_if.m_axis_cc_tdata, cpl(CPL_UR, 11'd0, 7'h0C, 8'h33, 32'h0));
    check("ur_cc_tkeep", bus_if.m_axis_cc_tkeep, 16'h0007);
    step();
    check("ur_err_pulse", bus_if.status_error_uncor, 0);
    check("ur_cc_done", bus_if.m_axis_cc_tvalid, 0);
    // read never acked
    send(hdr(REQ_MEM_RD, 11'd1, 24'h000008, 8'h44, 32'h0), 4'hF, 1'b1);
    n = 0;
    m = 0;
    for (int i = 0; i < 400 && !bus_if.m_axis_cc_tvalid; i++) begin
      n += int'(bus_if.reg_rd_en);
      m += int'(bus_if.status_error_uncor);
      step();
    end
    check("to_cc_valid", bus_if.m_axis_cc_tvalid, 1);
    check("to_rd_en_cycles", n, 256);
    check("to_cc_data", bus_if.m_axis_cc_tdata, cpl(CPL_SC, 11'd1, 7'h08, 8'h44, 32'hFFFFFFFF));
    m += int'(bus_if.status_error_uncor);
    step();
    m += int'(bus_if.status_error_uncor);
    check("to_err_pulses", m, 1);
    // asynchronous reset while a read is pending
    send(hdr(REQ_MEM_RD, 11'd1, 24'h000020, 8'h55, 32'h0), 4'hF, 1'b1);
    check("ra_rd_en", bus_if.reg_rd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ra_rd_en_async", bus_if.reg_rd_en, 0);
    step();
    rst = 1'b0;
    bus_if.reg_ack = 1'b1;
    bus_if.reg_rd_data = 32'h99999999;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= bus_if.m_axis_cc_tvalid | bus_if.reg_rd_en;
      step();
    end
    bus_if.reg_ack = 1'b0;
    check("ra_no_cc", seen, 0);
    check("ra_tready", bus_if.s_axis_cq_tready, 1);
    send(hdr(REQ_MEM_WR, 11'd1, 24'h000040, 8'h66, 32'h0BADF00D), 4'h3, 1'b1);
    check("ra_wr_en", bus_if.reg_wr_en, 1);
    check("ra_wr_fields", {bus_if.reg_addr, bus_if.reg_wr_data, bus_if.reg_wr_strb}, {24'h000040, 32'h0BADF00D, 4'h3});
    bus_if.reg_ack = 1'b1;
    step();
    bus_if.reg_ack = 1'b0;
    check("ra_wr_done", {bus_if.reg_wr_en, bus_if.s_axis_cq_tready, bus_if.m_axis_cc_tvalid}, 3'b010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcie_cq_reg_completer.md
PCIE_CQ_REG_COMPLETER -- requirements
Module: pcie_cq_reg_completer

Interface
REQ-001 Parameters SHALL be: AXIS_PCIE_DATA_WIDTH, default 512, CQ/CC data width; AXIS_PCIE_KEEP_WIDTH, default AXIS_PCIE_DATA_WIDTH/32, dword keep width; AXIS_PCIE_CQ_USER_WIDTH, default 183; AXIS_PCIE_CC_USER_WIDTH, default 81; REG_ADDR_WIDTH, default 24, byte address width (BAR0 aperture); TIMEOUT, default 256, register-ack timeout in cycles.
REQ-002 The block SHALL use one clock and one reset: clk input 1 (all logic on rising edge); rst input 1 (asynchronous, active-high).
REQ-003 CQ sink ports SHALL be: s_axis_cq_tdata in DATA_WIDTH; s_axis_cq_tkeep in KEEP_WIDTH; s_axis_cq_tvalid in 1; s_axis_cq_tready out 1; s_axis_cq_tlast in 1; s_axis_cq_tuser in CQ_USER_WIDTH, first_be in [3:0].
REQ-004 CC source ports SHALL be: m_axis_cc_tdata out DATA_WIDTH; m_axis_cc_tkeep out KEEP_WIDTH; m_axis_cc_tvalid out 1; m_axis_cc_tready in 1; m_axis_cc_tlast out 1; m_axis_cc_tuser out CC_USER_WIDTH.
REQ-005 Register ports SHALL be: reg_addr out REG_ADDR_WIDTH (dword-aligned byte address); reg_wr_data out 32; reg_wr_strb out 4; reg_wr_en out 1; reg_rd_en out 1; reg_rd_data in 32; reg_ack in 1; plus status_error_uncor out 1 (one-cycle pulse per UR or timeout).

Function
REQ-006 The FSM SHALL have states IDLE, WRITE, READ, CPL, DROP.
REQ-007 In IDLE, s_axis_cq_tready SHALL be 1; a header beat SHALL be decoded from type [78:75], dword count [74:64], address [63:2], requester ID [95:80], tag [103:96], function [111:104], TC [123:121], attr [126:124].
REQ-008 Memory write (type 0001) with dword count 1 SHALL latch address/data [159:128]/first_be and go to WRITE; otherwise it SHALL be discarded silently (to DROP if tlast=0, else IDLE).
REQ-009 Memory read (type 0000) with dword count 1 SHALL go to READ; any other non-posted type, or a read with dword count != 1, SHALL go to CPL with status UR (001), no data.
REQ-010 Posted types other than memory write SHALL be discarded silently (to DROP if tlast=0).
REQ-011 WRITE/READ SHALL hold reg_wr_en/reg_rd_en high with stable reg_addr/data/strb until the cycle reg_ack=1 (inclusive), then deassert next cycle; WRITE returns to IDLE (or DROP if header beat lacked tlast), READ captures reg_rd_data and goes to CPL with status SC (000).
REQ-012 A timeout counter SHALL count cycles in WRITE/READ; at TIMEOUT cycles without ack, enable SHALL drop, status_error_uncor SHALL pulse, and a read SHALL complete SC with data 0xFFFFFFFF.
REQ-013 CPL SHALL present one single-beat completion: lower address [6:0] = {addr[6:2], offset of lowest set first_be bit, 0 if none}; byte count [28:16] = 4 (0 for UR... UR byte count 4); dword count [42:32] = 1 for SC, 0 for UR; status [45:43]; requester ID [63:48]; tag [71:64]; function [79:72]; TC [91:89]; attr [94:92]; data [127:96]; all other bits 0.
REQ-014 CPL tkeep SHALL be 0x000F (SC) or 0x0007 (UR); tlast=1; tuser=0; tvalid held with stable payload until tready=1, then IDLE.
REQ-015 DROP SHALL hold tready=1 and return to IDLE on accepted tlast beat.
REQ-016 Only one request SHALL be outstanding; tready SHALL be 0 in WRITE, READ, CPL.
REQ-017 Latency SHALL be: header accept to reg enable 1 cycle; reg_ack to CC tvalid 1 cycle.

Reset
REQ-018 On rst: state IDLE; m_axis_cc_tvalid, reg_wr_en, reg_rd_en, status_error_uncor 0; s_axis_cq_tready 1 after release; counter 0; data/address registers 0.
REQ-019 Reset mid-operation SHALL abandon the request with no completion emitted afterwards.

Structure
REQ-020 CQ request type codes, CC status codes, and descriptor field offsets SHALL reside in a shared package pcie_us_pkg.
REQ-021 The block SHALL be a single module; no sub-module.

Verification
REQ-022 Write: type 0001, count 1, addr 0x000100, data 0xDEADBEEF, be 0xF, ack after 3 cycles -> reg_wr_en 3 cycles, addr 0x100, strb 0xF, no CC.
REQ-023 Read: addr 0x000204, tag 0x2A, be 0xF, ack with 0x12345678 -> CC SC, dword count 1, lower address 0x04, tag 0x2A, data 0x12345678, tkeep 0x000F.
REQ-024 Backpressure: CC tready low 5 cycles -> payload stable, CQ tready 0 throughout, single beat accepted.
REQ-025 Unsupported: read dword count 4 -> UR completion, dword count 0, tkeep 0x0007, status_error_uncor pulse, no reg access.
REQ-026 Timeout: read with no ack -> after 256 cycles CC SC data 0xFFFFFFFF, one status_error_uncor pulse.
REQ-027 Reset during READ -> rd_en 0 immediately, no CC after release, next write processed normally.
